// File: rtl/i2s_rx_if.sv
// Bundle between an I2S source (bclk/lrclk/sdata) and the receiver's parallel sample outputs.
interface i2s_rx_if #(
  parameter int unsigned SAMPLE_W = 16
);
  logic                bclk;
  logic                lrclk;
  logic                sdata;
  logic [SAMPLE_W-1:0] left_data;
  logic [SAMPLE_W-1:0] right_data;
  logic                sample_valid;
  logic                slot_err;

  modport master (
    output bclk, lrclk, sdata,
    input  left_data, right_data, sample_valid, slot_err
  );

  modport slave (
    input  bclk, lrclk, sdata,
    output left_data, right_data, sample_valid, slot_err
  );
endinterface

// File: rtl/i2s_rx.sv
// I2S slave receiver: oversamples bclk/lrclk/sdata in the clk domain and delivers
// MSB-aligned left/right samples with a one-cycle valid pulse per complete pair.
module i2s_rx #(
  parameter int unsigned SAMPLE_W = 16,
  parameter int unsigned CNT_W    = 6
) (
  input  logic    clk,
  input  logic    rst,
  i2s_rx_if.slave bus
);

  typedef enum logic [0:0] {SYNC = 1'b0, RUN = 1'b1} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t              state, state_nxt;
  logic [1:0]          bclk_sr, lr_sr, sd_sr;
  logic                bclk_prev;
  logic                lr_prev;
  logic                primed;
  logic [CNT_W-1:0]    bit_cnt;
  logic [SAMPLE_W-1:0] shreg;
  logic [SAMPLE_W-1:0] word_cap;
  logic                brise, lr_change, take_bit, close_nxt;
  logic                pend, pend_lr, pend_short;
  logic [SAMPLE_W-1:0] pend_word;
  logic [SAMPLE_W-1:0] left_q, right_q;
  logic                valid_q, err_q, left_ok;

  // 2-FF synchronizers plus the bclk edge-detect register
  always_ff @(posedge clk) begin
    if (rst) begin
      bclk_sr   <= '0;
      lr_sr     <= '0;
      sd_sr     <= '0;
      bclk_prev <= 1'b0;
    end else begin
      bclk_sr   <= {bclk_sr[0], bus.bclk};
      lr_sr     <= {lr_sr[0], bus.lrclk};
      sd_sr     <= {sd_sr[0], bus.sdata};
      bclk_prev <= bclk_sr[1];
    end
  end

  // The first brise after reset only learns the current lrclk level, so a
  // slot already in progress at reset can never look like a fresh slot.
  always_comb begin
    brise     = bclk_sr[1] & ~bclk_prev;
    lr_change = brise & primed & (lr_sr[1] != lr_prev);
    take_bit  = bit_cnt < CNT_W'(SAMPLE_W);
    word_cap  = take_bit ? {shreg[SAMPLE_W-2:0], sd_sr[1]} : shreg;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= SYNC;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    close_nxt = 1'b0;
    if (lr_change) begin
      if (state == SYNC) state_nxt = RUN;
      else               close_nxt = 1'b1;
    end
  end

  // Slot capture on each bclk rise; a closing slot is handed to the commit stage
  always_ff @(posedge clk) begin
    if (rst) begin
      primed     <= 1'b0;
      lr_prev    <= 1'b0;
      bit_cnt    <= '0;
      shreg      <= '0;
      pend       <= 1'b0;
      pend_lr    <= 1'b0;
      pend_short <= 1'b0;
      pend_word  <= '0;
    end else begin
      pend <= close_nxt;
      if (brise) begin
        primed  <= 1'b1;
        lr_prev <= lr_sr[1];
        if (lr_change) begin
          pend_word  <= word_cap;
          pend_lr    <= lr_prev;
          pend_short <= bit_cnt < CNT_W'(SAMPLE_W - 1);
          shreg      <= '0;
          bit_cnt    <= '0;
        end else begin
          shreg   <= word_cap;
          bit_cnt <= (bit_cnt == CNT_MAX) ? bit_cnt : bit_cnt + CNT_W'(1);
        end
      end
    end
  end

  // Commit: update the channel register and pulse valid/error
  always_ff @(posedge clk) begin
    if (rst) begin
      left_q  <= '0;
      right_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      left_ok <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      if (pend) begin
        if (pend_short) begin
          err_q   <= 1'b1;
          left_ok <= 1'b0;
        end else if (!pend_lr) begin
          left_q  <= pend_word;
          left_ok <= 1'b1;
        end else begin
          right_q <= pend_word;
          valid_q <= left_ok;
          left_ok <= 1'b0;
        end
      end
    end
  end

  assign bus.left_data    = left_q;
  assign bus.right_data   = right_q;
  assign bus.sample_valid = valid_q;
  assign bus.slot_err     = err_q;

endmodule
